// File: rtl/deserializer_if.sv
// Serial-receive link bundle: qualified bit stream in, completed word plus status out.
// Latency: none (wires only).
// Backpressure: none on the bit stream; the consumer acknowledges words with in_read.
interface deserializer_if #(
  parameter int WIDTH = 8
);
  logic             in_bit;
  logic             in_enable;
  logic             in_sync;
  logic             in_read;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_overrun;
  logic             out_busy;

  // Producer/consumer side: drives the serial bits and the read acknowledge
  modport master (
    output in_bit, in_enable, in_sync, in_read,
    input  out_data, out_valid, out_overrun, out_busy
  );

  // Deserializer side
  modport slave (
    input  in_bit, in_enable, in_sync, in_read,
    output out_data, out_valid, out_overrun, out_busy
  );
endinterface

// File: rtl/deserializer.sv
// Collects one qualified serial bit per cycle into a WIDTH-bit word, presented on valid/read.
// Latency: word visible one cycle after the edge sampling its last bit.
// Backpressure: none on the bit stream; an unread word is overwritten and sticky overrun is set.
module deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          in_clock,
  input  logic          in_reset,
  deserializer_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sr,   w_sr_nxt;
  logic [CW-1:0]    r_cnt,  w_cnt_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_first;
  logic             w_done;

  // Candidate shift-register contents: normal shift, and a fresh word holding only the current bit
  always_comb begin
    if (MSB_FIRST) begin
      w_shift = {r_sr[WIDTH-2:0], bus.in_bit};
      w_first = WIDTH'(bus.in_bit);
    end else begin
      w_shift = {bus.in_bit, r_sr[WIDTH-1:1]};
      w_first = {bus.in_bit, {(WIDTH-1){1'b0}}};
    end
  end

  // Next-state: sync restart beats completion; completion beats read; read only clears a held word
  always_comb begin
    w_sr_nxt      = r_sr;
    w_cnt_nxt     = r_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_overrun_nxt = r_overrun;
    w_done        = 1'b0;
    if (bus.in_sync) begin
      w_cnt_nxt = bus.in_enable ? CW'(1) : '0;
      w_sr_nxt  = bus.in_enable ? w_first : '0;
    end else if (bus.in_enable) begin
      w_sr_nxt = w_shift;
      if (r_cnt == LAST) begin
        w_cnt_nxt = '0;
        w_done    = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
    if (w_done) begin
      w_data_nxt  = w_shift;
      w_valid_nxt = 1'b1;
      if (r_valid && !bus.in_read) begin
        w_overrun_nxt = 1'b1;
      end
    end else if (bus.in_read && r_valid) begin
      w_valid_nxt = 1'b0;
    end
  end

  // State registers with synchronous reset overriding every other input
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_sr      <= w_sr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign bus.out_data    = r_data;
  assign bus.out_valid   = r_valid;
  assign bus.out_overrun = r_overrun;
  assign bus.out_busy    = (r_cnt != '0);
endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: MSB-first and LSB-first instances share one stimulus stream.
// Expected words are queued as the last bit is driven and popped on the completing edge.
// A small cycle model tracks count, valid and overrun.
module tb_deserializer;
  logic in_clock;
  logic in_reset;

  deserializer_if #(.WIDTH(8)) bm ();
  deserializer_if #(.WIDTH(8)) bl ();

  deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .bus      (bm)
  );

  deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .bus      (bl)
  );

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  int         m_cnt   = 0;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  logic [7:0] m_dm    = 8'h00;
  logic [7:0] m_dl    = 8'h00;

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare just after it
  task automatic step(input logic b, input logic en, input logic sy, input logic rd, input logic rst);
    logic done;
    bm.in_bit = b;  bm.in_enable = en; bm.in_sync = sy; bm.in_read = rd;
    bl.in_bit = b;  bl.in_enable = en; bl.in_sync = sy; bl.in_read = rd;
    in_reset  = rst;
    @(posedge in_clock);
    done = !rst && en && !sy && (m_cnt == 7);
    if (rst) begin
      m_cnt = 0; m_valid = 1'b0; m_ovr = 1'b0; m_dm = 8'h00; m_dl = 8'h00;
    end else begin
      if (done) begin
        if (m_valid && !rd) m_ovr = 1'b1;
        m_valid = 1'b1;
        if (q_m.size() != 0) m_dm = q_m.pop_front(); else m_dm = 8'hxx;
        if (q_l.size() != 0) m_dl = q_l.pop_front(); else m_dl = 8'hxx;
      end else if (rd && m_valid) begin
        m_valid = 1'b0;
      end
      if (sy)      m_cnt = en ? 1 : 0;
      else if (en) m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
    end
    #1;
    check("data_msb",  bm.out_data,    m_dm);
    check("data_lsb",  bl.out_data,    m_dl);
    check("valid_msb", bm.out_valid,   m_valid);
    check("valid_lsb", bl.out_valid,   m_valid);
    check("overrun",   bm.out_overrun, m_ovr);
    check("busy_msb",  bm.out_busy,    (m_cnt != 0));
    check("busy_lsb",  bl.out_busy,    (m_cnt != 0));
  endtask

  // Send a word first-bit-first as w[7]..w[0]; optional idle gap, sync on first bit, read on last
  task automatic send_word(input logic [7:0] w, input int gap_after, input int gap_len,
                           input logic sync_first, input logic read_last);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        q_m.push_back(w);
        q_l.push_back(rev8(w));
      end
      step(w[7-i], 1'b1, (i == 0) && sync_first, (i == 7) && read_last, 1'b0);
      if (i == gap_after) begin
        repeat (gap_len) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic word and read
    send_word(8'hAA, -1, 0, 1'b0, 1'b0);
    check("aa_word", bm.out_data, 8'hAA);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("aa_hold_after_read", bm.out_data, 8'hAA);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gap of three idle cycles after bit 4; LSB-first instance sees the bit-reversed word
    send_word(8'hB5, 3, 3, 1'b0, 1'b0);
    check("b5_msb", bm.out_data, 8'hB5);
    check("b5_lsb", bl.out_data, 8'hAD);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: sticky through a read, cleared by reset
    send_word(8'h3C, -1, 0, 1'b0, 1'b0);
    send_word(8'hC3, 2, 1, 1'b0, 1'b0);
    check("c3_word", bm.out_data, 8'hC3);
    check("c3_overrun", bm.out_overrun, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("overrun_cleared", bm.out_overrun, 1'b0);

    // Completion with a simultaneous read: no overrun
    send_word(8'h11, -1, 0, 1'b0, 1'b0);
    send_word(8'h22, -1, 0, 1'b0, 1'b1);
    check("22_word", bm.out_data, 8'h22);
    check("22_no_overrun", bm.out_overrun, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Sync with enable low after garbage
    send_bits(5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'h5A, -1, 0, 1'b0, 1'b0);
    check("5a_sync_idle", bm.out_data, 8'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Sync together with the first bit
    send_bits(5);
    send_word(8'h5A, -1, 0, 1'b1, 1'b0);
    check("5a_sync_bit", bm.out_data, 8'h5A);
    check("5a_sync_bit_lsb", bl.out_data, 8'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Sync on a would-be completion edge suppresses the completion
    send_bits(7);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sync_no_complete", bm.out_valid, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-word, then a full word
    send_word(8'h77, -1, 0, 1'b0, 1'b0);
    send_bits(4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_data",  bm.out_data,  8'h00);
    check("rst_valid", bm.out_valid, 1'b0);
    check("rst_busy",  bm.out_busy,  1'b0);
    send_word(8'hF0, 1, 2, 1'b0, 1'b0);
    check("f0_word", bm.out_data, 8'hF0);
    check("f0_lsb",  bl.out_data, 8'h0F);

    check("sb_drain", q_m.size() + q_l.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
Receive-side counterpart of the serializer. Collects a serial bit stream, one bit per enabled clock cycle, into a parallel word. Presents each completed word on a valid/read handshake and flags overrun. Sits at the receiving end of the serial link, driven by serializer out_bit plus a qualifying enable, and feeds a parallel consumer.

Parameters:
WIDTH, 8, word length in bits (2 or more)
MSB_FIRST, 1, 1 = first received bit lands in out_data[WIDTH-1]; 0 = first bit lands in out_data[0]

Ports:
in_clock  input  1  system clock; all state updates on rising edge
in_reset  input  1  synchronous, active-high reset
in_bit  input  1  serial data bit, sampled only when in_enable=1
in_enable  input  1  bit-valid qualifier; one bit accepted per cycle while high
in_sync  input  1  word-alignment restart; discards any partial word
in_read  input  1  consumer acknowledge of the current out_data
out_data  output  WIDTH  last completed word
out_valid  output  1  out_data holds an unread word
out_overrun  output  1  sticky; a completed word replaced an unread one
out_busy  output  1  partial word in progress (bit count != 0)

Behaviour:
- State: shift register sr[WIDTH-1:0]; bit counter cnt from 0 to WIDTH-1 ($clog2(WIDTH) bits); output registers.
- Reset (in_reset=1 at a rising edge): sr=0, cnt=0, out_data=0, out_valid=0, out_overrun=0. in_reset overrides all other inputs, including mid-word.
- Shift on each edge with in_enable=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], in_bit}.
  - MSB_FIRST=0: sr <= {in_bit, sr[WIDTH-1:1]}.
  - cnt <= cnt+1.
- in_enable=0: sr and cnt hold. Gaps of any length between bits are legal.
- Word completion: an edge with in_enable=1 and cnt==WIDTH-1.
  - out_data <= assembled word, including the current in_bit.
  - cnt <= 0 and out_valid <= 1.
  - Latency: out_valid and new out_data are visible in the cycle after the edge that samples the last bit.
- Handshake:
  - in_read=1 while out_valid=1 and no completion: out_valid <= 0; out_data holds its value.
  - in_read while out_valid=0 is ignored.
- Completion while out_valid=1 and in_read=0: out_data is overwritten with the new word, out_valid stays 1, out_overrun <= 1.
- Completion with in_read=1 in the same edge: new word is loaded, out_valid stays 1, no overrun.
- out_overrun is sticky and cleared only by in_reset.
- in_sync=1 at an edge:
  - With in_enable=0: cnt <= 0 and sr <= 0.
  - With in_enable=1: the current in_bit becomes bit 1 of a new word, so cnt <= 1 and sr holds only that bit.
  - in_sync never affects out_data, out_valid or out_overrun.
  - in_sync together with a would-be completion: no completion occurs; the sync rule applies.
- out_busy = (cnt != 0), combinational from the registered cnt.
- No combinational path from inputs to out_data, out_valid or out_overrun.

Test Plan:
- Reset with WIDTH=8, MSB_FIRST=1; send 1,0,1,0,1,0,1,0 on 8 consecutive enabled cycles -> out_data=8'hAA and out_valid=1 exactly one cycle after the 8th sampling edge; out_busy high after bit 1 and low after bit 8. Assert in_read for one cycle -> out_valid=0, out_data stays 8'hAA.
- Send 1,0,1,1,0,1,0,1 with in_enable low for 3 cycles after bit 4 -> out_data=8'hB5. Repeat with MSB_FIRST=0 -> out_data=8'hAD.
- Complete 8'h3C without in_read, then send 8'hC3 -> out_data=8'hC3, out_valid=1, out_overrun=1. out_overrun stays 1 after in_read and clears only after in_reset.
- Complete 8'h11, then hold in_read=1 on the completion edge of 8'h22 -> out_data=8'h22, out_valid=1, out_overrun=0.
- After 5 bits of garbage, pulse in_sync with in_enable=0, then send 8'h5A -> out_data=8'h5A. Repeat with in_sync and in_enable both high on the first bit -> same result.
- Assert in_reset after 4 bits -> all outputs 0 next cycle. A following full 8'hF0 -> out_data=8'hF0.
